// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline stage register with a 2-entry skid buffer.
// Carries a control bundle (zeroed on bubble/flush) and a data bundle between stages.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-low reset
//   flush            synchronous squash of all held entries
//   in_valid/ready   upstream handshake; in_ready depends on registered state only
//   in_ctrl/in_data  upstream control and data bundles
//   out_valid/ready  downstream handshake
//   out_ctrl/data    output bundles; out_ctrl is all-zero while out_valid=0
//   stall_cnt        saturating back-pressure cycle count
//
// Optional feature: define STALL_CNT_EN to build the stall counter; otherwise
// stall_cnt is tied to 0 and no counter flops exist.

module pipe_skid_stage #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 160,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              in_fire;
    logic              out_fire;

    // Both handshake signals come straight from the state register, so
    // there is no combinational path from out_ready to in_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush) begin
            // Data registers hold; only control is cleared so that any
            // stale content can never assert a write enable.
            state     <= EMPTY;
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else if (in_fire) begin
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                        state     <= FULL;
                    end else if (out_fire) begin
                        main_ctrl <= '0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                        state     <= ONE;
                    end
                end
                default: begin
                    main_ctrl <= '0;
                    state     <= EMPTY;
                end
            endcase
        end
    end

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of cycles where a valid word is blocked downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (out_valid && !out_ready && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed table, hand sequences and randomized
// stimulus against a queue-based model of pipe_skid_stage.

module tb_pipe_skid_stage;

    localparam int CW = 16;
    localparam int DW = 160;
    localparam int NW = 4;
    localparam int SAT = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [NW-1:0] stall_cnt;

    int n_vec = 0;
    int n_bad = 0;

    pipe_skid_stage #(
        .CTRL_W(CW),
        .DATA_W(DW),
        .CNT_W (NW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic [CW-1:0] ic;
        logic          ordy;
        logic          fl;
        logic          ev;
        logic [CW-1:0] ec;
        logic          er;
    } vec_t;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } word_t;

    vec_t  tbl[16];
    word_t q[$];

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] dfun(input logic [CW-1:0] c);
        return {10{c ^ 16'h5a5a}};
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int k = 0; k < 5; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic vec_t mk(input logic iv, input logic [CW-1:0] ic,
                                input logic ordy, input logic fl,
                                input logic ev, input logic [CW-1:0] ec,
                                input logic er);
        vec_t v;
        v.iv = iv; v.ic = ic; v.ordy = ordy; v.fl = fl;
        v.ev = ev; v.ec = ec; v.er = er;
        return v;
    endfunction

    task automatic drive(input logic iv, input logic [CW-1:0] ic,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = dfun(ic);
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        logic [CW-1:0] exp_c;

        // stream 1..5 with out_ready=1
        tbl[0]  = mk(1, 16'h0001, 1, 0, 1, 16'h0001, 1);
        tbl[1]  = mk(1, 16'h0002, 1, 0, 1, 16'h0002, 1);
        tbl[2]  = mk(1, 16'h0003, 1, 0, 1, 16'h0003, 1);
        tbl[3]  = mk(1, 16'h0004, 1, 0, 1, 16'h0004, 1);
        tbl[4]  = mk(1, 16'h0005, 1, 0, 1, 16'h0005, 1);
        tbl[5]  = mk(0, 16'h0000, 1, 0, 0, 16'h0000, 1);
        // back-pressure: A held, B in skid, C refused
        tbl[6]  = mk(1, 16'h00a0, 0, 0, 1, 16'h00a0, 1);
        tbl[7]  = mk(1, 16'h00b0, 0, 0, 1, 16'h00a0, 0);
        tbl[8]  = mk(1, 16'h00c0, 0, 0, 1, 16'h00a0, 0);
        tbl[9]  = mk(0, 16'h0000, 1, 0, 1, 16'h00b0, 1);
        tbl[10] = mk(0, 16'h0000, 1, 0, 0, 16'h0000, 1);
        // flush while FULL with C offered
        tbl[11] = mk(1, 16'h0a0a, 0, 0, 1, 16'h0a0a, 1);
        tbl[12] = mk(1, 16'h0b0b, 0, 0, 1, 16'h0a0a, 0);
        tbl[13] = mk(1, 16'h0c0c, 0, 1, 0, 16'h0000, 1);
        tbl[14] = mk(0, 16'h0000, 1, 0, 0, 16'h0000, 1);
        tbl[15] = mk(0, 16'h0000, 1, 0, 0, 16'h0000, 1);

        rst = 1'b0;
        drive(0, 16'h0, 0, 0);
        repeat (3) step();
        check("reset out_valid", out_valid, 0);
        check("reset out_ctrl", out_ctrl, 0);
        check("reset out_data", out_data, 0);
        check("reset in_ready", in_ready, 1);
        check("reset stall_cnt", stall_cnt, 0);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].iv, tbl[i].ic, tbl[i].ordy, tbl[i].fl);
            step();
            check($sformatf("vec%0d out_valid", i), out_valid, tbl[i].ev);
            check($sformatf("vec%0d out_ctrl", i), out_ctrl, tbl[i].ec);
            check($sformatf("vec%0d in_ready", i), in_ready, tbl[i].er);
            if (tbl[i].ev)
                check($sformatf("vec%0d out_data", i), out_data,
                      dfun(tbl[i].ec));
        end

        // async reset while FULL, between clock edges
        drive(1, 16'h0011, 0, 0);
        step();
        drive(1, 16'h0022, 0, 0);
        step();
        check("pre-areset in_ready", in_ready, 0);
        #2;
        rst = 1'b0;
        #1;
        check("areset out_valid", out_valid, 0);
        check("areset out_data", out_data, 0);
        check("areset out_ctrl", out_ctrl, 0);
        check("areset in_ready", in_ready, 1);
        drive(0, 16'h0, 0, 0);
        step();
        rst = 1'b1;
        check("post-areset in_ready", in_ready, 1);
        drive(1, 16'h0033, 0, 0);
        step();
        check("post-areset out_ctrl", out_ctrl, 16'h0033);
        drive(0, 16'h0, 0, 0);

`ifdef STALL_CNT_EN
        repeat (20) step();
        check("stall sat", stall_cnt, SAT);
        step();
        check("stall hold", stall_cnt, SAT);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("stall after flush", stall_cnt, SAT);
        check("flush out_valid", out_valid, 0);
`else
        repeat (20) step();
        check("stall_cnt tied", stall_cnt, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush out_valid", out_valid, 0);
`endif

        // randomized run against a FIFO model
        rst = 1'b0;
        step();
        rst = 1'b1;
        q.delete();
        cnt = 0;
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_ctrl   = CW'($urandom);
            in_data   = rand_data();

            exp_c = (q.size() > 0) ? q[0].c : '0;
            check($sformatf("rnd%0d in_ready", i), in_ready, q.size() < 2);
            check($sformatf("rnd%0d out_valid", i), out_valid, q.size() > 0);
            check($sformatf("rnd%0d out_ctrl", i), out_ctrl, exp_c);
            if (q.size() > 0)
                check($sformatf("rnd%0d out_data", i), out_data, q[0].d);
`ifdef STALL_CNT_EN
            check($sformatf("rnd%0d stall_cnt", i), stall_cnt, cnt);
`else
            check($sformatf("rnd%0d stall_cnt", i), stall_cnt, 0);
`endif

            if (q.size() > 0 && !out_ready && cnt < SAT) cnt++;
            if (flush) begin
                q.delete();
            end else begin
                logic can_in;
                can_in = (q.size() < 2);
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (in_valid && can_in) begin
                    word_t w;
                    w.c = in_ctrl;
                    w.d = in_data;
                    q.push_back(w);
                end
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
